// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the digit-serial multiplier.
//   DIGIT_W   - width of one multiplier digit (radix-4 digits)
//   MAX_W     - widest operand top_digit() can scan
//   state_e   - controller states IDLE / CALC / DONE
//   top_digit - index of the highest nonzero DIGIT_W-bit digit (0 when the
//               value is zero)
package mult_pkg;

  localparam int DIGIT_W = 2;
  localparam int MAX_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int top_digit(input logic [MAX_W-1:0] v);
    int hi;
    hi = 0;
    for (int k = 0; k < MAX_W / DIGIT_W; k++) begin
      if (v[k*DIGIT_W +: DIGIT_W] != 2'b00) begin
        hi = k;
      end
    end
    return hi;
  endfunction

endpackage

// File: rtl/mult2x2.sv
// mult2x2: combinational 2-bit x 2-bit unsigned multiplier built from
// partial-product gates (no multiply operator).
//   x - 2-bit operand
//   y - 2-bit operand
//   z - 4-bit product x*y
module mult2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] z
);

  logic pp00_s;
  logic pp01_s;
  logic pp10_s;
  logic pp11_s;
  logic c1_s;

  assign pp00_s = x[0] & y[0];
  assign pp01_s = x[0] & y[1];
  assign pp10_s = x[1] & y[0];
  assign pp11_s = x[1] & y[1];
  // carry out of the weight-2 column feeds the weight-4 column
  assign c1_s   = pp01_s & pp10_s;

  assign z[0] = pp00_s;
  assign z[1] = pp01_s ^ pp10_s;
  assign z[2] = pp11_s ^ c1_s;
  assign z[3] = pp11_s & c1_s;

endmodule

// File: rtl/mult_seq_digit.sv
// mult_seq_digit: sequential unsigned multiplier that consumes one radix-4
// digit of b per cycle. Each cycle a full row (a * b digit) is formed by
// DIGITS mult2x2 cells and added into the accumulator at weight 4^idx.
// With EARLY_EXIT=1 the operation ends as soon as no nonzero b digit remains.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_ready only while idle)
//   a, b                - unsigned operands, WIDTH bits
//   out_valid/out_ready - result handshake, p held until accepted
//   p                   - product, 2*WIDTH bits
module mult_seq_digit
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int ROW_W  = WIDTH + DIGIT_W;
  localparam int P_W    = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]              state_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [P_W-1:0]          p_r;
  logic [P_W-1:0]          acc_r;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        last_idx_r;
  logic [WIDTH-1:0]        a_r;
  logic [WIDTH-1:0]        b_r;

  logic [DIGIT_W-1:0]      b_dig_s;
  logic [DIGITS-1:0][3:0]  pp_s;
  logic [ROW_W-1:0]        row_s;
  logic [P_W-1:0]          acc_next_s;
  logic [IDX_W-1:0]        last_idx_s;

  // current multiplier digit selected by the digit index
  always_comb begin
    b_dig_s = b_r[{idx_r, 1'b0} +: DIGIT_W];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_cell
    mult2x2 u_cell (
      .x (a_r[k*DIGIT_W +: DIGIT_W]),
      .y (b_dig_s),
      .z (pp_s[k])
    );
  end

  // row = sum of the digit products of a, each at weight 4^k
  always_comb begin
    row_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      row_s = row_s + (ROW_W'(pp_s[k]) << (DIGIT_W * k));
    end
  end

  // accumulator update; the final sum fits 2*WIDTH bits so no carry is lost
  always_comb begin
    acc_next_s = acc_r + (P_W'(row_s) << {idx_r, 1'b0});
  end

  // index of the final CALC cycle, decided once at accept time from b
  always_comb begin
    if (EARLY_EXIT != 0) begin
      last_idx_s = IDX_W'(top_digit(MAX_W'(b)));
    end else begin
      last_idx_s = LAST_IDX;
    end
  end

  // controller, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      p_r         <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
      last_idx_r  <= '0;
      a_r         <= '0;
      b_r         <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            acc_r      <= '0;
            idx_r      <= '0;
            last_idx_r <= last_idx_s;
            in_ready_r <= 1'b0;
            state_r    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + IDX_W'(1);
          if (idx_r == last_idx_r) begin
            p_r         <= acc_next_s;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign p         = p_r;

endmodule

// File: tb/tb_mult_seq_digit.sv
module tb_mult_seq_digit;

  localparam int NL          = 16;
  localparam int PER_LANE    = 65536 / NL;
  localparam int SWEEP_LIMIT = 60000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // directed DUTs share one input set
  logic        d_in_valid;
  logic        d_out_ready;
  logic [7:0]  d_a8;
  logic [7:0]  d_b8;
  logic [15:0] d_a16;
  logic [15:0] d_b16;
  logic        r0, v0, r1, v1, r2, v2;
  logic [15:0] p0, p1;
  logic [31:0] p2;

  int          n0_seen, n1_seen, n2_seen;
  logic [31:0] p0_seen, p1_seen, p2_seen;

  // exhaustive sweep lanes
  logic [NL-1:0]       l_iv;
  logic [NL-1:0]       l_ir;
  logic [NL-1:0]       l_ov;
  logic [NL-1:0]       l_or;
  logic [NL-1:0][7:0]  l_a;
  logic [NL-1:0][7:0]  l_b;
  logic [NL-1:0][15:0] l_p;
  logic                sweep_go;
  int                  sent [NL];
  logic [NL-1:0]       will_acc;

  // behavioural model state per lane
  bit          m_pend  [NL];
  bit          m_valid [NL];
  bit          m_ready [NL];
  int          m_due   [NL];
  logic [15:0] m_prod  [NL];
  logic [15:0] m_vis   [NL];
  int          xfers;
  int          cyc;

  mult_seq_digit #(.WIDTH(8), .EARLY_EXIT(0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(r0),
    .a(d_a8), .b(d_b8), .out_valid(v0), .out_ready(d_out_ready), .p(p0));

  mult_seq_digit #(.WIDTH(8), .EARLY_EXIT(1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(r1),
    .a(d_a8), .b(d_b8), .out_valid(v1), .out_ready(d_out_ready), .p(p1));

  mult_seq_digit #(.WIDTH(16), .EARLY_EXIT(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(r2),
    .a(d_a16), .b(d_b16), .out_valid(v2), .out_ready(d_out_ready), .p(p2));

  for (genvar g = 0; g < NL; g++) begin : g_lane
    mult_seq_digit #(.WIDTH(8), .EARLY_EXIT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(l_iv[g]), .in_ready(l_ir[g]),
      .a(l_a[g]), .b(l_b[g]), .out_valid(l_ov[g]), .out_ready(l_or[g]),
      .p(l_p[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // CALC cycles an operation needs: 1 + index of the highest nonzero radix-4 digit
  function automatic int n_cyc(input logic [31:0] bv);
    int n;
    n = 1;
    for (int k = 1; k < 16; k++) begin
      if ((bv >> (2 * k)) != 32'd0) n = k + 1;
    end
    return n;
  endfunction

  task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
    check("pre_accept_ready", 64'({r0, r1, r2}), 64'(3'b111));
    d_a8 = av[7:0]; d_b8 = bv[7:0]; d_a16 = av; d_b16 = bv;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    check("post_accept_ready", 64'({r0, r1, r2}), 64'(3'b000));
  endtask

  // counts edges after the accept edge until each DUT shows out_valid
  task automatic wait_results();
    n0_seen = -1; n1_seen = -1; n2_seen = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (n0_seen < 0 && v0) begin n0_seen = c; p0_seen = 32'(p0); end
      if (n1_seen < 0 && v1) begin n1_seen = c; p1_seen = 32'(p1); end
      if (n2_seen < 0 && v2) begin n2_seen = c; p2_seen = p2; end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check("xfer_valid_low", 64'({v0, v1, v2}), 64'(3'b000));
    check("xfer_ready_high", 64'({r0, r1, r2}), 64'(3'b111));
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input int e0, input int e1, input int e2,
                        input logic [31:0] ep8, input logic [31:0] ep16, input bit rel);
    start_op(av, bv);
    wait_results();
    check("n_ee0", 64'(n0_seen), 64'(e0));
    check("n_ee1", 64'(n1_seen), 64'(e1));
    check("n_w16", 64'(n2_seen), 64'(e2));
    check("p_ee0", 64'(p0_seen), 64'(ep8));
    check("p_ee1", 64'(p1_seen), 64'(ep8));
    check("p_w16", 64'(p2_seen), 64'(ep16));
    if (rel) release_out();
  endtask

  initial begin : lane_driver
    int j;
    l_iv = '0; l_or = '0; l_a = '0; l_b = '0; will_acc = '0;
    for (int k = 0; k < NL; k++) sent[k] = 0;
    wait (sweep_go);
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (will_acc[k]) begin
          sent[k]++;
          l_iv[k] = 1'b0;
        end
        if (!l_iv[k]) begin
          if (sent[k] < PER_LANE && $urandom_range(0, 1) == 1) begin
            j = k + NL * sent[k];
            l_a[k] = 8'(j >> 8);
            l_b[k] = 8'(j);
            l_iv[k] = 1'b1;
          end else begin
            l_a[k] = 8'($urandom);
            l_b[k] = 8'($urandom);
          end
        end
        l_or[k] = ($urandom_range(0, 3) != 0);
        will_acc[k] = l_iv[k] && l_ir[k];
      end
    end
  end

  initial begin : main
    total = 0; bad = 0; sweep_go = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0;
    d_a8 = 8'd0; d_b8 = 8'd0; d_a16 = 16'd0; d_b16 = 16'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'({r0, r1, r2}), 64'(3'b111));
    check("rst_out_valid", 64'({v0, v1, v2}), 64'(3'b000));
    check("rst_p_ee1", 64'(p1), 64'd0);
    check("rst_lane_ready", 64'(l_ir), 64'(16'hFFFF));
    check("rst_lane_valid", 64'(l_ov), 64'(16'h0000));

    check("pin_n_b0", 64'(n_cyc(32'd0)), 64'd1);
    check("pin_n_b3", 64'(n_cyc(32'd3)), 64'd1);
    check("pin_n_b40", 64'(n_cyc(32'h40)), 64'd4);
    check("pin_n_bffff", 64'(n_cyc(32'hFFFF)), 64'd8);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // accepted at the first rising edge after reset release
    run_op(16'h00FF, 16'h00FF, 4, 4, 4, 32'hFE01, 32'hFE01, 1'b1);
    @(negedge clk); run_op(16'd200, 16'd3, 4, 1, 1, 32'd600, 32'd600, 1'b1);
    @(negedge clk); run_op(16'h00AB, 16'h0000, 4, 1, 1, 32'd0, 32'd0, 1'b1);
    @(negedge clk); run_op(16'h005A, 16'h0040, 4, 4, 4, 32'd5760, 32'd5760, 1'b1);
    @(negedge clk); run_op(16'hFFFF, 16'hFFFF, 4, 4, 8, 32'hFE01, 32'hFFFE0001, 1'b1);
    @(negedge clk); run_op(16'h1234, 16'h0100, 4, 1, 5, 32'd0, 32'h00123400, 1'b1);

    // backpressure: result held, new request waits for the return to idle
    @(negedge clk); run_op(16'h0012, 16'h0034, 4, 3, 3, 32'd936, 32'd936, 1'b0);
    @(negedge clk);
    d_a8 = 8'd7; d_b8 = 8'd9; d_a16 = 16'd7; d_b16 = 16'd9; d_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'({v0, v1, v2}), 64'(3'b111));
      check("hold_p_ee1", 64'(p1), 64'd936);
      check("hold_p_w16", 64'(p2), 64'd936);
      check("hold_ready", 64'({r0, r1, r2}), 64'(3'b000));
    end
    @(negedge clk); d_out_ready = 1'b1;
    @(posedge clk); #1; d_out_ready = 1'b0;
    check("xfer_hold_valid", 64'({v0, v1, v2}), 64'(3'b000));
    check("xfer_hold_ready", 64'({r0, r1, r2}), 64'(3'b111));
    check("xfer_hold_p", 64'(p1), 64'd936);
    @(posedge clk); #1;
    check("late_accept", 64'({r0, r1, r2}), 64'(3'b000));
    d_in_valid = 1'b0;
    wait_results();
    check("late_n_ee0", 64'(n0_seen), 64'd4);
    check("late_n_ee1", 64'(n1_seen), 64'd2);
    check("late_n_w16", 64'(n2_seen), 64'd2);
    check("late_p_ee1", 64'(p1_seen), 64'd63);
    check("late_p_w16", 64'(p2_seen), 64'd63);
    release_out();

    // reset in the middle of a calculation
    @(negedge clk); start_op(16'hFFFF, 16'hFFFF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'({v0, v1, v2}), 64'(3'b000));
    check("abort_ready", 64'({r0, r1, r2}), 64'(3'b111));
    check("abort_p", 64'({p0, p1, p2}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_hold_valid", 64'({v0, v1, v2}), 64'(3'b000));
      check("abort_hold_p", 64'({p0, p1, p2}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h000D, 16'h00B7, 4, 4, 4, 32'd2379, 32'd2379, 1'b1);

    // exhaustive 8-bit sweep across lanes with random gaps and backpressure
    for (int k = 0; k < NL; k++) begin
      m_pend[k] = 1'b0; m_valid[k] = 1'b0; m_ready[k] = 1'b1;
      m_due[k] = 0; m_prod[k] = 16'd0; m_vis[k] = 16'd0;
    end
    xfers = 0;
    cyc = 0;
    sweep_go = 1'b1;
    while (xfers < 65536 && cyc < SWEEP_LIMIT && bad < 200) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < NL; k++) begin
        if (m_valid[k] && l_or[k]) begin
          m_pend[k] = 1'b0;
          xfers++;
        end
        if (l_iv[k] && m_ready[k]) begin
          m_pend[k] = 1'b1;
          m_prod[k] = 16'(l_a[k]) * 16'(l_b[k]);
          m_due[k]  = cyc + n_cyc(32'(l_b[k]));
        end
        m_valid[k] = m_pend[k] && (cyc >= m_due[k]);
        if (m_valid[k]) m_vis[k] = m_prod[k];
        m_ready[k] = !m_pend[k];
        check($sformatf("lane%0d", k), 64'({l_ov[k], l_ir[k], l_p[k]}),
              64'({m_valid[k], m_ready[k], m_vis[k]}));
      end
    end
    check("sweep_ops_done", 64'(xfers), 64'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
